spi_config_master: RTL and testbench

//  SPI initiator driving the configuration port of the FIR engine (cs/mosi/spiClk): bench, MCU

---
 rtl/fir_spi_pkg.sv | 30 +++
 rtl/spi_clk_divider.sv | 29 ++
 rtl/spi_config_master.sv | 131 +++++++++++++
 tb/tb_spi_config_master.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_spi_pkg.sv
// rtl/fir_spi_pkg.sv - shared definitions for the FIR engine SPI configuration port
package fir_spi_pkg;

  localparam int SPI_WORD_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    STALL,
    HOLD,
    GAP
  } spi_state_e;

  // Config word layout decoded by the FIR engine's SPI slave: opcode in the top nibble.
  localparam int CFG_OP_WIDTH      = 4;
  localparam int CFG_PAYLOAD_WIDTH = SPI_WORD_WIDTH - CFG_OP_WIDTH;

  typedef enum logic [CFG_OP_WIDTH-1:0] {
    CFG_OP_NOP    = 4'h0,
    CFG_OP_COEF   = 4'h1,
    CFG_OP_CLKCFG = 4'h2,
    CFG_OP_SCALE  = 4'h3
  } cfg_op_e;

  function automatic logic [SPI_WORD_WIDTH-1:0] cfgWord(input cfg_op_e op,
                                                        input logic [CFG_PAYLOAD_WIDTH-1:0] payload);
    return {op, payload};
  endfunction

endpackage

// File: rtl/spi_clk_divider.sv
// rtl/spi_clk_divider.sv - half-period tick generator for the SPI clock
module spi_clk_divider #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic halfPhaseDone
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign halfPhaseDone = enable && !clear && (count == LAST);

endmodule

// File: rtl/spi_config_master.sv
// rtl/spi_config_master.sv - mode-0 SPI initiator feeding config words to the FIR engine
module spi_config_master
  import fir_spi_pkg::*;
#(
  parameter int WORD_WIDTH = SPI_WORD_WIDTH,
  parameter int CLK_DIV    = 4,
  parameter int CS_IDLE    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_WIDTH-1:0] inData,
  input  logic                  inLast,
  input  logic                  inValid,
  output logic                  inReady,
  output logic                  cs,
  output logic                  spiClk,
  output logic                  mosi,
  output logic                  busy,
  output logic                  done
);

  localparam int BW = $clog2(WORD_WIDTH);
  localparam int GW = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_IDLE - 1);

  spi_state_e            state, stateNext;
  logic [WORD_WIDTH-1:0] shiftReg, shiftNext;
  logic [BW-1:0]         bitCnt, bitCntNext;
  logic [GW-1:0]         gapCnt, gapCntNext;
  logic                  lastWord, lastWordNext;
  logic                  csNext, spiClkNext, mosiNext, doneNext;
  logic                  halfPhaseDone, divEnable, wordEnd, accept;

  assign divEnable = (state == SHIFT) || (state == HOLD);

  spi_clk_divider #(.CLK_DIV(CLK_DIV)) uDivider (
    .clk,
    .reset,
    .enable       (divEnable),
    .clear        (!divEnable),
    .halfPhaseDone
  );

  // Final cycle of bit 0's high phase: the only in-frame slot for a back-to-back word.
  assign wordEnd = (state == SHIFT) && halfPhaseDone && spiClk && (bitCnt == '0);
  assign inReady = reset && ((state == IDLE) || (state == STALL) || (wordEnd && !lastWord));
  assign accept  = inValid && inReady;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      shiftReg <= '0;
      bitCnt   <= '0;
      gapCnt   <= '0;
      lastWord <= 1'b0;
      cs       <= 1'b1;
      spiClk   <= 1'b0;
      mosi     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= stateNext;
      shiftReg <= shiftNext;
      bitCnt   <= bitCntNext;
      gapCnt   <= gapCntNext;
      lastWord <= lastWordNext;
      cs       <= csNext;
      spiClk   <= spiClkNext;
      mosi     <= mosiNext;
      done     <= doneNext;
    end
  end

  always_comb begin
    stateNext    = state;
    shiftNext    = shiftReg;
    bitCntNext   = bitCnt;
    gapCntNext   = gapCnt;
    lastWordNext = lastWord;
    csNext       = cs;
    spiClkNext   = spiClk;
    mosiNext     = mosi;
    doneNext     = 1'b0;
    if (accept) begin
      // Same load path from IDLE, STALL and the back-to-back boundary.
      stateNext    = SHIFT;
      shiftNext    = inData;
      bitCntNext   = BW'(WORD_WIDTH - 1);
      lastWordNext = inLast;
      csNext       = 1'b0;
      spiClkNext   = 1'b0;
      mosiNext     = inData[WORD_WIDTH-1];
    end else begin
      case (state)
        SHIFT: begin
          if (halfPhaseDone) begin
            spiClkNext = !spiClk;
            if (spiClk) begin
              if (bitCnt != '0) begin
                bitCntNext = bitCnt - 1'b1;
                shiftNext  = shiftReg << 1;
                mosiNext   = shiftReg[WORD_WIDTH-2];
              end else begin
                stateNext = lastWord ? HOLD : STALL;
              end
            end
          end
        end
        HOLD: begin
          if (halfPhaseDone) begin
            stateNext  = GAP;
            csNext     = 1'b1;
            mosiNext   = 1'b0;
            gapCntNext = '0;
            doneNext   = 1'b1;
          end
        end
        GAP: begin
          if (gapCnt == GAP_LAST) begin
            stateNext = IDLE;
          end else begin
            gapCntNext = gapCnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_config_master.sv
// tb/tb_spi_config_master.sv - randomized bench for spi_config_master against a mode-0 slave model
module tb_spi_config_master;

  localparam int W     = 16;
  localparam int DIV0  = 2;
  localparam int GAP0  = 4;
  localparam int DIV1  = 1;
  localparam int GAP1  = 3;
  localparam int LIMIT = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         resetN  [2];
  logic [W-1:0] inData  [2];
  logic         inLast  [2];
  logic         inValid [2];
  logic         inReady [2];
  logic         cs      [2];
  logic         spiClk  [2];
  logic         mosi    [2];
  logic         busy    [2];
  logic         done    [2];

  spi_config_master #(.WORD_WIDTH(W), .CLK_DIV(DIV0), .CS_IDLE(GAP0)) dut0 (
    .clk(clk), .reset(resetN[0]), .inData(inData[0]), .inLast(inLast[0]), .inValid(inValid[0]),
    .inReady(inReady[0]), .cs(cs[0]), .spiClk(spiClk[0]), .mosi(mosi[0]), .busy(busy[0]), .done(done[0])
  );

  spi_config_master #(.WORD_WIDTH(W), .CLK_DIV(DIV1), .CS_IDLE(GAP1)) dut1 (
    .clk(clk), .reset(resetN[1]), .inData(inData[1]), .inLast(inLast[1]), .inValid(inValid[1]),
    .inReady(inReady[1]), .cs(cs[1]), .spiClk(spiClk[1]), .mosi(mosi[1]), .busy(busy[1]), .done(done[1])
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Slave-side observations, sampled on the falling clk edge.
  logic [W-1:0] bitAcc [2] = '{default: '0};
  logic prevClk [2] = '{default: 1'b0};
  logic prevCs [2] = '{default: 1'b1};
  logic prevMosi [2] = '{default: 1'b0};
  logic prevBusy [2] = '{default: 1'b0};
  int nBits [2] = '{default: 0};
  int lowRun [2] = '{default: 0};
  int highRun [2] = '{default: 0};
  int csLowRun [2] = '{default: 0};
  int csHighRun [2] = '{default: 0};
  int busyTail [2] = '{default: 0};
  int frameRises [2] = '{default: 0};
  int frameMaxLow [2] = '{default: 0};
  int frameReady [2] = '{default: 0};
  int frameLowChg [2] = '{default: 0};
  int lastCsLow [2] = '{default: 0};
  int lastCsHigh [2] = '{default: 0};
  int lastBusyTail [2] = '{default: 0};
  int lastRises [2] = '{default: 0};
  int lastMaxLow [2] = '{default: 0};
  int lastReady [2] = '{default: 0};
  int lastLowChg [2] = '{default: 0};
  int doneCnt [2] = '{default: 0};
  int acceptCnt [2] = '{default: 0};
  int glitch [2] = '{default: 0};
  int shortLow [2] = '{default: 0};
  int badHigh [2] = '{default: 0};
  int highChg [2] = '{default: 0};
  int gapReady [2] = '{default: 0};
  int mosiIdle [2] = '{default: 0};
  int frameErr [2] = '{default: 0};
  logic [W-1:0] rxQ0 [$];
  logic [W-1:0] rxQ1 [$];
  logic [W-1:0] expQ0 [$];
  logic [W-1:0] expQ1 [$];

  function automatic int divOf(input int i);
    return (i == 0) ? DIV0 : DIV1;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!resetN[i]) begin
        nBits[i]     <= 0;
        prevClk[i]   <= 1'b0;
        prevCs[i]    <= 1'b1;
        prevMosi[i]  <= 1'b0;
        prevBusy[i]  <= 1'b0;
        lowRun[i]    <= 0;
        highRun[i]   <= 0;
        csLowRun[i]  <= 0;
        csHighRun[i] <= 0;
      end else begin
        prevClk[i]  <= spiClk[i];
        prevCs[i]   <= cs[i];
        prevMosi[i] <= mosi[i];
        prevBusy[i] <= busy[i];
        if (spiClk[i] && !prevClk[i]) begin
          frameRises[i] <= frameRises[i] + 1;
          if (cs[i]) glitch[i] <= glitch[i] + 1;
          if (lowRun[i] < divOf(i)) shortLow[i] <= shortLow[i] + 1;
          if (lowRun[i] > frameMaxLow[i]) frameMaxLow[i] <= lowRun[i];
          lowRun[i]  <= 0;
          highRun[i] <= 1;
          bitAcc[i]  <= {bitAcc[i][W-2:0], mosi[i]};
          if (nBits[i] == W - 1) begin
            nBits[i] <= 0;
            if (i == 0) rxQ0.push_back({bitAcc[i][W-2:0], mosi[i]});
            else rxQ1.push_back({bitAcc[i][W-2:0], mosi[i]});
          end else begin
            nBits[i] <= nBits[i] + 1;
          end
        end else if (spiClk[i]) begin
          highRun[i] <= highRun[i] + 1;
          if (mosi[i] != prevMosi[i]) highChg[i] <= highChg[i] + 1;
        end else begin
          if (prevClk[i] && highRun[i] != divOf(i)) badHigh[i] <= badHigh[i] + 1;
          lowRun[i] <= cs[i] ? 0 : lowRun[i] + 1;
          if (!cs[i] && !prevCs[i] && !prevClk[i] && mosi[i] != prevMosi[i])
            frameLowChg[i] <= frameLowChg[i] + 1;
        end
        if (done[i]) doneCnt[i] <= doneCnt[i] + 1;
        if (inReady[i] && inValid[i]) acceptCnt[i] <= acceptCnt[i] + 1;
        if (inReady[i] && busy[i]) frameReady[i] <= frameReady[i] + 1;
        if (cs[i] && busy[i] && inReady[i]) gapReady[i] <= gapReady[i] + 1;
        if (cs[i] && mosi[i]) mosiIdle[i] <= mosiIdle[i] + 1;
        if (!cs[i]) csLowRun[i] <= csLowRun[i] + 1;
        if (!busy[i] && prevBusy[i]) lastBusyTail[i] <= busyTail[i];
        if (!cs[i] && prevCs[i]) begin
          lastCsHigh[i]  <= csHighRun[i];
          frameMaxLow[i] <= 0;
          frameRises[i]  <= 0;
          frameReady[i]  <= 0;
          frameLowChg[i] <= 0;
        end
        if (cs[i] && !prevCs[i]) begin
          lastCsLow[i]  <= csLowRun[i];
          csLowRun[i]   <= 0;
          csHighRun[i]  <= 1;
          busyTail[i]   <= busy[i] ? 1 : 0;
          lastRises[i]  <= frameRises[i];
          lastMaxLow[i] <= frameMaxLow[i];
          lastReady[i]  <= frameReady[i];
          lastLowChg[i] <= frameLowChg[i];
          if (nBits[i] != 0) frameErr[i] <= frameErr[i] + 1;
          nBits[i] <= 0;
        end else if (cs[i]) begin
          csHighRun[i] <= csHighRun[i] + 1;
          if (busy[i]) busyTail[i] <= busyTail[i] + 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic sendWord(input int i, input logic [W-1:0] d, input logic last, input int preDelay);
    int n;
    n = 0;
    repeat (preDelay) tick();
    inData[i]  = d;
    inLast[i]  = last;
    inValid[i] = 1'b1;
    if (i == 0) expQ0.push_back(d);
    else expQ1.push_back(d);
    while (!inReady[i] && n < LIMIT) begin
      tick();
      n++;
    end
    if (n >= LIMIT) check("accept_timeout", n, 0);
    tick();
    inValid[i] = 1'b0;
    inLast[i]  = 1'($urandom);
    inData[i]  = W'($urandom);
  endtask

  task automatic waitIdle(input int i);
    int n;
    n = 0;
    while (busy[i] && n < LIMIT) begin
      tick();
      n++;
    end
    if (n >= LIMIT) check("idle_timeout", n, 0);
    repeat (2) tick();
  endtask

  task automatic checkRx(input int i, input string tag);
    int ne;
    logic [W-1:0] e;
    logic [W-1:0] r;
    ne = (i == 0) ? expQ0.size() : expQ1.size();
    for (int k = 0; k < ne; k++) begin
      if (i == 0) e = expQ0.pop_front();
      else e = expQ1.pop_front();
      if (((i == 0) ? rxQ0.size() : rxQ1.size()) == 0) begin
        check({tag, "_rx_missing"}, k, ne);
        break;
      end
      if (i == 0) r = rxQ0.pop_front();
      else r = rxQ1.pop_front();
      check({tag, "_rx_word"}, r, e);
    end
    expQ0.delete();
    expQ1.delete();
    check({tag, "_rx_extra"}, (i == 0) ? rxQ0.size() : rxQ1.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, a0, g0, p;
    logic [W-1:0] w0, w1;
    for (int i = 0; i < 2; i++) begin
      resetN[i]  = 1'b0;
      inData[i]  = '0;
      inLast[i]  = 1'b0;
      inValid[i] = 1'b0;
    end
    repeat (3) tick();
    check("rst_cs", cs[0], 1);
    check("rst_spiclk", spiClk[0], 0);
    check("rst_mosi", mosi[0], 0);
    check("rst_ready", inReady[0], 0);
    check("rst_busy", busy[0], 0);
    check("rst_done", done[0], 0);
    resetN[0] = 1'b1;
    resetN[1] = 1'b1;
    tick();
    check("idle_ready", inReady[0], 1);

    // Single word frame
    d0 = doneCnt[0];
    sendWord(0, 16'hA5C3, 1'b1, 0);
    waitIdle(0);
    check("t1_rises", lastRises[0], W);
    check("t1_cs_low", lastCsLow[0], W * 2 * DIV0 + DIV0);
    check("t1_done", doneCnt[0] - d0, 1);
    check("t1_busy_tail", lastBusyTail[0], GAP0);
    checkRx(0, "t1");

    // Back-to-back words, continuous spiClk
    a0 = acceptCnt[0];
    sendWord(0, 16'h1234, 1'b0, 0);
    sendWord(0, 16'hFFFF, 1'b1, 0);
    waitIdle(0);
    check("t2_rises", lastRises[0], 2 * W);
    check("t2_cs_low", lastCsLow[0], 2 * W * 2 * DIV0 + DIV0);
    check("t2_max_low", lastMaxLow[0], DIV0);
    check("t2_ready_in_frame", lastReady[0], 1);
    check("t2_accepts", acceptCnt[0] - a0, 2);
    checkRx(0, "t2");

    // Underrun at the word boundary
    w0 = W'($urandom);
    w1 = W'($urandom);
    p  = W * 2 * DIV0 + 10;
    sendWord(0, w0, 1'b0, 0);
    sendWord(0, w1, 1'b1, p);
    waitIdle(0);
    check("t3_rises", lastRises[0], 2 * W);
    check("t3_stall_low", lastMaxLow[0], (p + 1 - W * 2 * DIV0) + DIV0);
    check("t3_cs_low", lastCsLow[0], 2 * W * 2 * DIV0 + DIV0 + (p + 1 - W * 2 * DIV0));
    check("t3_ready_in_frame", lastReady[0], 1 + (p + 1 - W * 2 * DIV0));
    check("t3_mosi_low_changes", lastLowChg[0], (w1[W-1] != w0[0]) ? 1 : 0);
    checkRx(0, "t3");

    // Reset mid-word aborts the frame
    sendWord(0, W'($urandom), 1'b1, 0);
    void'(expQ0.pop_back());
    p = 0;
    while (nBits[0] != 9 && p < LIMIT) begin
      tick();
      p++;
    end
    if (p >= LIMIT) check("t4_bit_timeout", p, 0);
    resetN[0] = 1'b0;
    #1;
    check("t4_cs", cs[0], 1);
    check("t4_spiclk", spiClk[0], 0);
    check("t4_mosi", mosi[0], 0);
    check("t4_busy", busy[0], 0);
    check("t4_ready", inReady[0], 0);
    repeat (2) tick();
    resetN[0] = 1'b1;
    tick();
    w0 = W'($urandom);
    sendWord(0, w0, 1'b1, 0);
    waitIdle(0);
    check("t4_rises", lastRises[0], W);
    checkRx(0, "t4");

    // inValid held through GAP
    d0 = doneCnt[0];
    g0 = gapReady[0];
    sendWord(0, W'($urandom), 1'b1, 0);
    sendWord(0, W'($urandom), 1'b1, 0);
    waitIdle(0);
    check("t5_cs_high_gap", lastCsHigh[0], GAP0 + 1);
    check("t5_gap_ready", gapReady[0] - g0, 0);
    check("t5_done", doneCnt[0] - d0, 2);
    checkRx(0, "t5");
    check("dut0_glitch", glitch[0], 0);
    check("dut0_short_low", shortLow[0], 0);
    check("dut0_bad_high", badHigh[0], 0);
    check("dut0_high_mosi_chg", highChg[0], 0);
    check("dut0_mosi_idle", mosiIdle[0], 0);
    check("dut0_frame_err", frameErr[0], 0);

    // Random frames at CLK_DIV=1
    d0 = doneCnt[1];
    for (int f = 0; f < 25; f++) begin
      int nw, stall;
      nw    = $urandom_range(1, 4);
      stall = ($urandom_range(0, 3) == 0) ? 1 : 0;
      for (int w = 0; w < nw; w++)
        sendWord(1, W'($urandom), (w == nw - 1), (stall != 0 && w > 0) ? $urandom_range(0, 2 * W * DIV1 + 6) : 0);
      waitIdle(1);
      if (stall == 0) check("t6_cs_low", lastCsLow[1], nw * W * 2 * DIV1 + DIV1);
      check("t6_rises", lastRises[1], nw * W);
      check("t6_busy_tail", lastBusyTail[1], GAP1);
      repeat ($urandom_range(0, 5)) tick();
    end
    checkRx(1, "t6");
    check("t6_done", doneCnt[1] - d0, 25);
    check("dut1_glitch", glitch[1], 0);
    check("dut1_short_low", shortLow[1], 0);
    check("dut1_bad_high", badHigh[1], 0);
    check("dut1_high_mosi_chg", highChg[1], 0);
    check("dut1_mosi_idle", mosiIdle[1], 0);
    check("dut1_gap_ready", gapReady[1], 0);
    check("dut1_frame_err", frameErr[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
